// File: rtl/aidc_lite_pkg.sv
// Shared types and constants for the ZRLE line-decompressor dispatcher.
package aidc_lite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eng_state_t;

  localparam int LINE_WRITES   = 8;
  localparam int DECOMP_WORD_W = 32;

endpackage

// File: rtl/aidc_lite_rr_pick.sv
// Round-robin first-idle finder: lowest offset from the pointer (with wrap) wins.
import aidc_lite_pkg::*;

module aidc_lite_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] idle_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);

  logic [W:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = |idle_i;
    idx     = '0;
    // Scan farthest offset first so the nearest idle engine overwrites it.
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + (W + 1)'(i);
      if (idx >= (W + 1)'(N)) idx = idx - (W + 1)'(N);
      if (idle_i[idx[W-1:0]]) grant_o = idx[W-1:0];
    end
  end

endmodule

// File: rtl/aidc_lite_decomp_sched.sv
// Dispatches compressed-line packets to idle engines and retires lines in dispatch order.
//   state | meaning
//   IDLE  | free, eligible for dispatch
//   RECV  | packet words arriving
//   DRAIN | eop seen, waiting for remaining line writes
//   DONE  | 8 writes seen, reserved until retired at the order-FIFO head
import aidc_lite_pkg::*;

module aidc_lite_decomp_sched #(
  parameter int NUM_ENG   = 4,
  parameter int ENG_W     = $clog2(NUM_ENG),
  parameter int TAG_W     = 8,
  parameter int MAX_WORDS = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_sop_i,
  input  logic                     in_eop_i,
  input  logic [DECOMP_WORD_W-1:0] in_data_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic [NUM_ENG-1:0]       eng_valid_o,
  output logic [NUM_ENG-1:0]       eng_sop_o,
  output logic [NUM_ENG-1:0]       eng_eop_o,
  output logic [DECOMP_WORD_W-1:0] eng_data_o,
  input  logic [NUM_ENG-1:0]       eng_wr_i,
  output logic                     cpl_valid_o,
  input  logic                     cpl_ready_i,
  output logic [ENG_W-1:0]         cpl_eng_o,
  output logic [TAG_W-1:0]         cpl_tag_o,
  output logic                     err_o
);

  localparam int PW = $clog2(MAX_WORDS + 1);
  localparam logic [ENG_W-1:0] LAST_ENG = ENG_W'(NUM_ENG - 1);

  function automatic logic [ENG_W-1:0] wrap_inc(input logic [ENG_W-1:0] v);
    return (v == LAST_ENG) ? '0 : v + 1'b1;
  endfunction

  eng_state_t                state_q [NUM_ENG];
  eng_state_t                state_d [NUM_ENG];
  logic [3:0]                wcnt_q  [NUM_ENG];
  logic [3:0]                wcnt_d  [NUM_ENG];
  logic [TAG_W-1:0]          tag_q   [NUM_ENG];
  logic [ENG_W-1:0]          fifo_q  [NUM_ENG];
  logic [ENG_W-1:0]          rd_ptr_q, wr_ptr_q, rr_q, cur_eng_q, grant, head;
  logic [ENG_W:0]            cnt_q;
  logic [PW-1:0]             pkt_words_q;
  logic                      in_pkt_q, init_q, err_q, err_set;
  logic                      any_idle, acc, disp, fwd, pop;
  logic [NUM_ENG-1:0]        idle_vec;
  logic [NUM_ENG-1:0]        eng_valid_q, eng_sop_q, eng_eop_q;
  logic [NUM_ENG-1:0]        eng_valid_d, eng_sop_d, eng_eop_d;
  logic [DECOMP_WORD_W-1:0]  eng_data_q, eng_data_d;

  aidc_lite_rr_pick #(.N(NUM_ENG), .W(ENG_W)) u_pick (
    .idle_i  (idle_vec),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .any_o   (any_idle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NUM_ENG; e++) begin
        state_q[e] <= IDLE;
        wcnt_q[e]  <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_set = (acc && !in_pkt_q && !in_sop_i) || (fwd && in_sop_i) ||
              (fwd && pkt_words_q == PW'(MAX_WORDS));
    for (int e = 0; e < NUM_ENG; e++) begin
      if (disp && grant == ENG_W'(e)) begin
        state_d[e] = in_eop_i ? DRAIN : RECV;
        wcnt_d[e]  = '0;
      end else if (fwd && in_eop_i && cur_eng_q == ENG_W'(e) && state_q[e] == RECV) begin
        state_d[e] = DRAIN;
      end
      if (eng_wr_i[e]) begin
        if (state_q[e] == RECV || state_q[e] == DRAIN) begin
          wcnt_d[e] = wcnt_q[e] + 1'b1;
          if (wcnt_q[e] == 4'(LINE_WRITES - 1)) state_d[e] = DONE;
        end else begin
          err_set = 1'b1;
        end
      end
      if (pop && head == ENG_W'(e)) state_d[e] = IDLE;
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ENG; e++) idle_vec[e] = (state_q[e] == IDLE);
    in_ready_o  = init_q && (in_pkt_q || any_idle);
    acc         = in_valid_i && in_ready_o;
    disp        = acc && !in_pkt_q && in_sop_i;
    fwd         = acc && in_pkt_q;
    head        = fifo_q[rd_ptr_q];
    cpl_valid_o = (cnt_q != '0) && (state_q[head] == DONE);
    pop         = cpl_valid_o && cpl_ready_i;
    cpl_eng_o   = head;
    cpl_tag_o   = tag_q[head];
  end

  // A sop arriving mid-packet is forwarded as a plain word, so no sop strobe.
  always_comb begin
    eng_valid_d = '0;
    eng_sop_d   = '0;
    eng_eop_d   = '0;
    eng_data_d  = '0;
    if (disp) begin
      eng_valid_d[grant] = 1'b1;
      eng_sop_d[grant]   = 1'b1;
      eng_eop_d[grant]   = in_eop_i;
      eng_data_d         = in_data_i;
    end else if (fwd) begin
      eng_valid_d[cur_eng_q] = 1'b1;
      eng_eop_d[cur_eng_q]   = in_eop_i;
      eng_data_d             = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q      <= 1'b0;
      err_q       <= 1'b0;
      in_pkt_q    <= 1'b0;
      cur_eng_q   <= '0;
      pkt_words_q <= '0;
      rr_q        <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      eng_valid_q <= '0;
      eng_sop_q   <= '0;
      eng_eop_q   <= '0;
      eng_data_q  <= '0;
      for (int e = 0; e < NUM_ENG; e++) begin
        tag_q[e]  <= '0;
        fifo_q[e] <= '0;
      end
    end else begin
      init_q      <= 1'b1;
      err_q       <= err_q || err_set;
      eng_valid_q <= eng_valid_d;
      eng_sop_q   <= eng_sop_d;
      eng_eop_q   <= eng_eop_d;
      eng_data_q  <= eng_data_d;
      if (disp) begin
        in_pkt_q          <= !in_eop_i;
        cur_eng_q         <= grant;
        pkt_words_q       <= PW'(1);
        rr_q              <= wrap_inc(grant);
        tag_q[grant]      <= in_tag_i;
        fifo_q[wr_ptr_q]  <= grant;
        wr_ptr_q          <= wrap_inc(wr_ptr_q);
      end else if (fwd) begin
        if (in_eop_i) in_pkt_q <= 1'b0;
        if (pkt_words_q != PW'(MAX_WORDS)) pkt_words_q <= pkt_words_q + 1'b1;
      end
      if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      cnt_q <= cnt_q + (ENG_W + 1)'(disp) - (ENG_W + 1)'(pop);
    end
  end

  assign eng_valid_o = eng_valid_q;
  assign eng_sop_o   = eng_sop_q;
  assign eng_eop_o   = eng_eop_q;
  assign eng_data_o  = eng_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aidc_lite_decomp_sched.sv
// Directed self-checking bench for the decompressor dispatcher/retirement controller.
module tb_aidc_lite_decomp_sched;

  logic        clk;
  logic        rst;
  logic        in_valid_i, in_ready_o, in_sop_i, in_eop_i;
  logic [31:0] in_data_i;
  logic [7:0]  in_tag_i;
  logic [3:0]  eng_valid_o, eng_sop_o, eng_eop_o, eng_wr_i;
  logic [31:0] eng_data_o;
  logic        cpl_valid_o, cpl_ready_i, err_o;
  logic [1:0]  cpl_eng_o;
  logic [7:0]  cpl_tag_o;

  int checks = 0;
  int errors = 0;

  aidc_lite_decomp_sched #(.NUM_ENG(4), .ENG_W(2), .TAG_W(8), .MAX_WORDS(17)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_sop_i    (in_sop_i),
    .in_eop_i    (in_eop_i),
    .in_data_i   (in_data_i),
    .in_tag_i    (in_tag_i),
    .eng_valid_o (eng_valid_o),
    .eng_sop_o   (eng_sop_o),
    .eng_eop_o   (eng_eop_o),
    .eng_data_o  (eng_data_o),
    .eng_wr_i    (eng_wr_i),
    .cpl_valid_o (cpl_valid_o),
    .cpl_ready_i (cpl_ready_i),
    .cpl_eng_o   (cpl_eng_o),
    .cpl_tag_o   (cpl_tag_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0; in_data_i = '0; in_tag_i = '0;
  endtask

  task automatic do_reset();
    idle_in();
    eng_wr_i = '0; cpl_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [31:0] d, input logic [7:0] tag);
    in_valid_i = 1'b1; in_sop_i = sop; in_eop_i = eop; in_data_i = d; in_tag_i = tag;
    cyc();
  endtask

  task automatic wr(input logic [3:0] mask, input int n);
    eng_wr_i = mask;
    repeat (n) cyc();
    eng_wr_i = '0;
  endtask

  task automatic test_reset();
    idle_in(); eng_wr_i = '0; cpl_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o} !== 12'h000) begin errors++; $display("FAIL reset_eng: got %h expected 000", {eng_valid_o, eng_sop_o, eng_eop_o}); end
    checks++; if ({cpl_valid_o, err_o, in_ready_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {cpl_valid_o, err_o, in_ready_o}); end
    checks++; if (eng_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", eng_data_o); end
    do_reset();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_single();
    do_reset();
    beat(1'b1, 1'b0, 32'hA000_0001, 8'h5A);
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o} !== 12'h110) begin errors++; $display("FAIL single_b0: got %h expected 110", {eng_valid_o, eng_sop_o, eng_eop_o}); end
    checks++; if (eng_data_o !== 32'hA000_0001) begin errors++; $display("FAIL single_d0: got %h expected a0000001", eng_data_o); end
    beat(1'b0, 1'b0, 32'h0000_00B2, 8'h00);
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o} !== 12'h100 || eng_data_o !== 32'hB2) begin errors++; $display("FAIL single_b1: got %h/%h expected 100/b2", {eng_valid_o, eng_sop_o, eng_eop_o}, eng_data_o); end
    beat(1'b0, 1'b1, 32'h0000_00C3, 8'h00);
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o} !== 12'h101 || eng_data_o !== 32'hC3) begin errors++; $display("FAIL single_b2: got %h/%h expected 101/c3", {eng_valid_o, eng_sop_o, eng_eop_o}, eng_data_o); end
    idle_in();
    cyc();
    checks++; if (eng_valid_o !== 4'b0 || eng_data_o !== 32'h0) begin errors++; $display("FAIL single_quiet: got %b/%h expected 0000/0", eng_valid_o, eng_data_o); end
    wr(4'b0001, 7);
    checks++; if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL single_7wr: got %b expected 0", cpl_valid_o); end
    wr(4'b0001, 1);
    checks++; if ({cpl_valid_o, cpl_eng_o, cpl_tag_o} !== {1'b1, 2'd0, 8'h5A}) begin errors++; $display("FAIL single_cpl: got %h expected %h", {cpl_valid_o, cpl_eng_o, cpl_tag_o}, {1'b1, 2'd0, 8'h5A}); end
    cpl_ready_i = 1'b1;
    cyc();
    cpl_ready_i = 1'b0;
    checks++; if ({cpl_valid_o, err_o} !== 2'b00) begin errors++; $display("FAIL single_retired: got %b expected 00", {cpl_valid_o, err_o}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_oh;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      exp_oh = 4'b0001 << p;
      beat(1'b1, 1'b0, 32'h100 + p, 8'h10 + 8'(p));
      checks++; if (eng_valid_o !== exp_oh || eng_sop_o !== exp_oh) begin errors++; $display("FAIL b2b_sop%0d: got %b/%b expected %b", p, eng_valid_o, eng_sop_o, exp_oh); end
      beat(1'b0, 1'b1, 32'h200 + p, 8'h00);
    end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready_o); end
    in_valid_i = 1'b1; in_sop_i = 1'b1; in_eop_i = 1'b0; in_data_i = 32'h500; in_tag_i = 8'h55;
    cyc();
    checks++; if (eng_valid_o !== 4'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0000", eng_valid_o); end
    wr(4'b0001, 8);
    checks++; if ({cpl_valid_o, cpl_eng_o, cpl_tag_o, in_ready_o} !== {1'b1, 2'd0, 8'h10, 1'b0}) begin errors++; $display("FAIL b2b_cpl0: got %h expected %h", {cpl_valid_o, cpl_eng_o, cpl_tag_o, in_ready_o}, {1'b1, 2'd0, 8'h10, 1'b0}); end
    cpl_ready_i = 1'b1;
    cyc();
    cpl_ready_i = 1'b0;
    checks++; if (in_ready_o !== 1'b1 || eng_valid_o !== 4'b0) begin errors++; $display("FAIL b2b_freed: got %b/%b expected 1/0000", in_ready_o, eng_valid_o); end
    cyc();
    checks++; if (eng_valid_o !== 4'b0001 || eng_sop_o !== 4'b0001 || eng_data_o !== 32'h500) begin errors++; $display("FAIL b2b_fifth: got %b/%b/%h expected 0001/0001/500", eng_valid_o, eng_sop_o, eng_data_o); end
    beat(1'b0, 1'b1, 32'h501, 8'h00);
    idle_in();
  endtask

  task automatic test_out_of_order();
    do_reset();
    beat(1'b1, 1'b0, 32'h11, 8'h11);
    beat(1'b0, 1'b1, 32'h12, 8'hEE);
    beat(1'b1, 1'b0, 32'h21, 8'h22);
    beat(1'b0, 1'b1, 32'h22, 8'hEE);
    idle_in();
    wr(4'b0010, 8);
    checks++; if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_blocked: got %b expected 0", cpl_valid_o); end
    wr(4'b0001, 7);
    checks++; if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_head7: got %b expected 0", cpl_valid_o); end
    wr(4'b0001, 1);
    for (int k = 0; k < 3; k++) begin
      checks++; if ({cpl_valid_o, cpl_eng_o, cpl_tag_o} !== {1'b1, 2'd0, 8'h11}) begin errors++; $display("FAIL ooo_hold%0d: got %h expected %h", k, {cpl_valid_o, cpl_eng_o, cpl_tag_o}, {1'b1, 2'd0, 8'h11}); end
      cyc();
    end
    cpl_ready_i = 1'b1;
    cyc();
    checks++; if ({cpl_valid_o, cpl_eng_o, cpl_tag_o} !== {1'b1, 2'd1, 8'h22}) begin errors++; $display("FAIL ooo_second: got %h expected %h", {cpl_valid_o, cpl_eng_o, cpl_tag_o}, {1'b1, 2'd1, 8'h22}); end
    cyc();
    cpl_ready_i = 1'b0;
    checks++; if (cpl_valid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL ooo_empty: got %b/%b expected 0/0", cpl_valid_o, err_o); end
  endtask

  task automatic test_single_beat();
    do_reset();
    beat(1'b1, 1'b1, 32'hD00D_0001, 8'h33);
    idle_in();
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o} !== 12'h111 || eng_data_o !== 32'hD00D_0001) begin errors++; $display("FAIL sb_beat: got %h/%h expected 111/d00d0001", {eng_valid_o, eng_sop_o, eng_eop_o}, eng_data_o); end
    wr(4'b0001, 7);
    checks++; if (cpl_valid_o !== 1'b0) begin errors++; $display("FAIL sb_7wr: got %b expected 0", cpl_valid_o); end
    wr(4'b0001, 1);
    checks++; if ({cpl_valid_o, cpl_eng_o, cpl_tag_o, err_o} !== {1'b1, 2'd0, 8'h33, 1'b0}) begin errors++; $display("FAIL sb_cpl: got %h expected %h", {cpl_valid_o, cpl_eng_o, cpl_tag_o, err_o}, {1'b1, 2'd0, 8'h33, 1'b0}); end
  endtask

  task automatic test_errors();
    do_reset();
    wr(4'b0100, 1);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_idle_wr: got %b expected 1", err_o); end
    repeat (3) cyc();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err_o); end
    beat(1'b1, 1'b1, 32'h9, 8'h09);
    idle_in();
    wr(4'b0001, 8);
    checks++; if (err_o !== 1'b0 || cpl_valid_o !== 1'b1) begin errors++; $display("FAIL err_8wr: got %b/%b expected 0/1", err_o, cpl_valid_o); end
    wr(4'b0001, 1);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_9th_wr: got %b expected 1", err_o); end
    do_reset();
    beat(1'b1, 1'b0, 32'h1, 8'h18);
    for (int w = 2; w <= 17; w++) beat(1'b0, 1'b0, 32'(w), 8'h00);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_17words: got %b expected 0", err_o); end
    beat(1'b0, 1'b1, 32'h12, 8'h00);
    idle_in();
    checks++; if (err_o !== 1'b1 || eng_valid_o !== 4'b0001 || eng_eop_o !== 4'b0001) begin errors++; $display("FAIL err_18words: got %b/%b/%b expected 1/0001/0001", err_o, eng_valid_o, eng_eop_o); end
    do_reset();
    beat(1'b0, 1'b0, 32'h77, 8'h00);
    idle_in();
    checks++; if (err_o !== 1'b1 || eng_valid_o !== 4'b0) begin errors++; $display("FAIL err_stray: got %b/%b expected 1/0000", err_o, eng_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    beat(1'b1, 1'b0, 32'h1, 8'hA1);
    beat(1'b0, 1'b1, 32'h2, 8'h00);
    beat(1'b1, 1'b0, 32'h3, 8'hA2);
    checks++; if (eng_valid_o !== 4'b0010) begin errors++; $display("FAIL rmid_busy: got %b expected 0010", eng_valid_o); end
    in_sop_i = 1'b0; in_data_i = 32'h4;
    rst = 1'b1;
    #1;
    checks++; if ({eng_valid_o, eng_sop_o, eng_eop_o, cpl_valid_o, err_o, in_ready_o} !== 15'h0 || eng_data_o !== 32'h0) begin errors++; $display("FAIL rmid_abort: got %h/%h expected 0/0", {eng_valid_o, eng_sop_o, eng_eop_o, cpl_valid_o, err_o, in_ready_o}, eng_data_o); end
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    cyc();
    beat(1'b1, 1'b1, 32'h5, 8'hA3);
    idle_in();
    checks++; if (eng_valid_o !== 4'b0001 || eng_sop_o !== 4'b0001) begin errors++; $display("FAIL rmid_restart: got %b/%b expected 0001/0001", eng_valid_o, eng_sop_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_single_beat();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
